// File: rtl/crossing_pkg.sv
// Shared widths and helpers for the crossing-count frequency estimator.
package crossing_pkg;

    localparam int DATA_W_DFLT = 16;
    localparam int CNT_W_DFLT  = 16;

    // Increment v, but stick at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        return (v >= max_v) ? max_v : v + 32'h1;
    endfunction

endpackage

// File: rtl/crossing_freq_est_if.sv
// Sample/result bundle between the host and the crossing frequency estimator.
interface crossing_freq_est_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] threshold;
    logic                     peak_v;
    logic                     est_v;
    logic signed [DATA_W-1:0] peak;
    logic                     peak_vout;
    logic [CNT_W-1:0]         count;
    logic                     count_vout;

    modport master (
        output x, threshold, peak_v, est_v,
        input  peak, peak_vout, count, count_vout
    );

    modport slave (
        input  x, threshold, peak_v, est_v,
        output peak, peak_vout, count, count_vout
    );
endinterface

// File: rtl/freq_count.sv
// Counts upward threshold crossings between consecutive valid samples.
module freq_count
    import crossing_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     valid,
    output logic [CNT_W-1:0]         count,
    output logic                     vout
);
    logic                     have_prev;
    logic signed [DATA_W-1:0] x_prev;
    logic                     up_cross;

    assign up_cross = (x_prev < threshold) && (x >= threshold);

    // have_prev doubles as the registered valid for burst edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_prev <= 1'b0;
            x_prev    <= '0;
            count     <= '0;
            vout      <= 1'b0;
        end else begin
            have_prev <= valid;
            vout      <= have_prev & ~valid;
            if (valid) begin
                x_prev <= x;
                if (!have_prev)
                    count <= '0;
                else if (up_cross)
                    count <= CNT_W'(sat_inc(32'(count), CNT_W));
            end
        end
    end
endmodule

// File: rtl/peak_find.sv
// Running signed maximum over each valid burst, with a burst-end pulse.
module peak_find #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     valid,
    output logic signed [DATA_W-1:0] peak,
    output logic                     vout
);
    logic v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= 1'b0;
            vout <= 1'b0;
            peak <= '0;
        end else begin
            v_q  <= valid;
            vout <= v_q & ~valid;
            // First sample of a burst always loads, even if below the old peak.
            if (valid && (!v_q || x > peak))
                peak <= x;
        end
    end
endmodule

// File: rtl/crossing_freq_est.sv
// Peak detector plus crossing counter; the two paths run independently.
module crossing_freq_est
    import crossing_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input logic          clk,
    input logic          rst,
    crossing_freq_est_if.slave bus
);
    peak_find #(
        .DATA_W (DATA_W)
    ) u_peak (
        .clk   (clk),
        .rst   (rst),
        .x     (bus.x),
        .valid (bus.peak_v),
        .peak  (bus.peak),
        .vout  (bus.peak_vout)
    );

    freq_count #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .x         (bus.x),
        .threshold (bus.threshold),
        .valid     (bus.est_v),
        .count     (bus.count),
        .vout      (bus.count_vout)
    );
endmodule

// File: tb/tb_crossing_freq_est.sv
// Bench: directed and random bursts against a burst-level reference model.
module tb_crossing_freq_est;
    logic clk = 1'b0;
    logic rst = 1'b1;

    crossing_freq_est_if #(.DATA_W(16), .CNT_W(16)) a ();
    crossing_freq_est_if #(.DATA_W(16), .CNT_W(4))  s ();

    crossing_freq_est #(.DATA_W(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    crossing_freq_est #(.DATA_W(16), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (s.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples of the current/last burst of each path.
    int pq[$];
    int eq[$];
    int et[$];
    bit p_prev, e_prev;
    bit exp_pv, exp_cv;

    function automatic int model_peak();
        int m;
        if (pq.size() == 0) return 0;
        m = pq[0];
        foreach (pq[i]) if (pq[i] > m) m = pq[i];
        return m;
    endfunction

    function automatic int model_cross();
        int n = 0;
        for (int i = 1; i < eq.size(); i++)
            if (eq[i-1] < et[i] && eq[i] >= et[i]) n++;
        return n;
    endfunction

    function automatic int min_i(input int p, input int q);
        return (p < q) ? p : q;
    endfunction

    task automatic cyc(input bit r, input bit pv, input bit ev,
                       input int xv, input int tv);
        @(negedge clk);
        check("peak",       int'($signed(a.peak)),  model_peak());
        check("peak_vout",  int'(a.peak_vout),      int'(exp_pv));
        check("count",      int'(a.count),          min_i(model_cross(), 65535));
        check("count_vout", int'(a.count_vout),     int'(exp_cv));
        check("count4",     int'(s.count),          min_i(model_cross(), 15));
        check("peak4",      int'($signed(s.peak)),  model_peak());
        rst = r;
        a.x = 16'(xv);  s.x = 16'(xv);
        a.threshold = 16'(tv); s.threshold = 16'(tv);
        a.peak_v = pv;  s.peak_v = pv;
        a.est_v = ev;   s.est_v = ev;
        if (r) begin
            pq.delete(); eq.delete(); et.delete();
            p_prev = 0; e_prev = 0; exp_pv = 0; exp_cv = 0;
        end else begin
            if (pv) begin
                if (!p_prev) pq.delete();
                pq.push_back(xv);
            end
            if (ev) begin
                if (!e_prev) begin eq.delete(); et.delete(); end
                eq.push_back(xv);
                et.push_back(tv);
            end
            exp_pv = p_prev && !pv;
            exp_cv = e_prev && !ev;
            p_prev = pv;
            e_prev = ev;
        end
    endtask

    int seq_a[10] = '{0, 100, 200, 100, 0, -100, -200, -100, 0, 100};
    int seq_n[3]  = '{-32768, -5, -300};
    int seq_b[5]  = '{49, 50, 50, 49, 50};

    initial begin
        a.x = '0; a.threshold = '0; a.peak_v = 0; a.est_v = 0;
        s.x = '0; s.threshold = '0; s.peak_v = 0; s.est_v = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Peak pass then estimation pass of the same segment.
        foreach (seq_a[i]) cyc(0, 1, 0, seq_a[i], 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        foreach (seq_a[i]) cyc(0, 0, 1, seq_a[i], 200 >>> 2);
        cyc(0, 0, 0, 0, 50);
        cyc(0, 0, 0, 0, 50);
        check("dir_peak",  int'($signed(a.peak)), 200);
        check("dir_count", int'(a.count), 2);
        // Negative peak and threshold-equality boundary, run concurrently.
        foreach (seq_n[i]) cyc(0, 1, 1, seq_n[i], 50);
        cyc(0, 0, 0, 0, 50);
        foreach (seq_b[i]) cyc(0, 1, 1, seq_b[i], 50);
        cyc(0, 0, 0, 0, 50);
        check("dir_eq_count", int'(a.count), 2);
        // Single-cycle gap: back-to-back bursts.
        cyc(0, 1, 1, 300, 50);
        cyc(0, 1, 1, 0, 50);
        cyc(0, 0, 0, 0, 50);
        cyc(0, 1, 1, -7, 50);
        cyc(0, 1, 1, 60, 50);
        cyc(0, 0, 0, 0, 50);
        cyc(0, 0, 0, 0, 50);
        check("dir_gap_peak", int'($signed(a.peak)), 60);
        // Twenty crossings: saturates the 4-bit counter.
        for (int i = 0; i < 40; i++) cyc(0, 0, 1, (i % 2) ? 100 : 0, 50);
        cyc(0, 0, 0, 0, 50);
        cyc(0, 0, 0, 0, 50);
        check("dir_sat16", int'(a.count), 20);
        check("dir_sat4",  int'(s.count), 15);
        // Reset mid-burst.
        cyc(0, 1, 1, 10, 5);
        cyc(0, 1, 1, 20, 5);
        cyc(1, 1, 1, 30, 5);
        cyc(0, 1, 1, -40, 5);
        cyc(0, 1, 1, 40, 5);
        cyc(0, 0, 0, 0, 5);
        cyc(0, 0, 0, 0, 5);
        // Random traffic.
        begin
            bit pv = 0, ev = 0;
            int tv = 0, xv;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(3) == 0) pv = ~pv;
                if ($urandom_range(3) == 0) ev = ~ev;
                if ($urandom_range(15) == 0) tv = int'($urandom_range(400)) - 200;
                if ($urandom_range(7) == 0)
                    xv = int'($signed(16'($urandom)));
                else
                    xv = int'($urandom_range(400)) - 200;
                cyc($urandom_range(199) == 0, pv, ev, xv, tv);
            end
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
